opb_register_simulink2ppc: RTL and testbench
============================================

// Module: opb_register_simulink2ppc
// PURPOSE
//  Fabric-to-software status register on the OPB bus. User logic pushes 32-bit samples
//  (qualified by user_valid); the PowerPC reads them by address. The block keeps a
//  "new data" flag and a saturating overrun counter, plus a small control register.
//  It sits beside the ppc2simulink trigger/config registers on the same OPB segment.
// PARAMETERS
//  C_BASEADDR    32'h01060200  base of the 256-byte window
//  C_HIGHADDR    32'h010602FF  top of the window
//  C_OPB_AWIDTH  32            OPB address width
//  C_OPB_DWIDTH  32            OPB data width
//  C_FAMILY      "virtex5"     target family (informational)
// PORTS
//  OPB_Clk        in   1   single clock for the bus and user sides
//  OPB_Rst_n      in   1   asynchronous active-low reset
//  OPB_ABus       in   [0:31]  address
//  OPB_BE         in   [0:3]   byte enables; BE[0] covers DBus[0:7], the MSB byte
//  OPB_DBus       in   [0:31]  write data
//  OPB_RNW        in   1   1=read, 0=write
//  OPB_select     in   1   transfer request
//  OPB_seqAddr    in   1   ignored
//  Sl_DBus        out  [0:31]  read data; all zero except in the ack cycle
//  Sl_xferAck     out  1   one-cycle transfer acknowledge
//  Sl_errAck      out  1   tied 0
//  Sl_retry       out  1   tied 0
//  Sl_toutSup     out  1   tied 0
//  user_data_in   in   [31:0]  sample from user logic
//  user_valid     in   1   capture strobe, one sample per cycle
// BEHAVIOUR
//  Bus mapping: Sl_DBus[0:31] = value[31:0], with bus bit 0 as the MSB.
//  Register map, by offset = OPB_ABus - C_BASEADDR:
//   0x00 DATA    RO  last captured sample
//   0x04 STATUS  RO  [31:16] overrun_cnt, [15:1] 0, [0] new
//   0x08 CONTROL RW  [0] freeze; [1] clear (write-1 pulse, reads 0); [31:2] read 0
//   0x0C-0xFC        acked; reads return 0; writes are dropped
//  Capture path, each cycle:
//   - If user_valid=1 and freeze=0: DATA <= user_data_in and new <= 1.
//     If new was already 1 and no clearing read occurs in this cycle, overrun_cnt
//     increments, saturating at 16'hFFFF.
//   - If freeze=1, user_valid is ignored entirely (no capture, no count).
//  Bus FSM, three states:
//   - IDLE: move to ACK when OPB_select=1 and the address is in range.
//   - ACK: Sl_xferAck=1 for exactly one cycle, then move to HOLD.
//   - HOLD: one cycle that ignores OPB_select, then return to IDLE.
//  Bus timing and data:
//   - Latency: select sampled at edge k; ack high during cycle k+1. No back-to-back acks.
//   - Read data is registered on entry to ACK, i.e. the register values at edge k.
//  Side effects:
//   - An acked read of DATA clears new at the end of the ack cycle.
//   - A capture in that same cycle wins: new stays 1, no overrun is counted, and the
//     bus returns the old sample.
//   - A CONTROL write takes effect at the end of the ack cycle, byte-gated: BE[3]
//     gates bits [7:0]; other bytes are ignored.
//   - clear=1 zeroes overrun_cnt and new (DATA is kept). clear beats a concurrent
//     capture: new=0, count=0.
//  Out-of-range or deselected cycles: no ack, and Sl_DBus=0 (the OPB wired-OR is safe).
//  Reset (async, OPB_Rst_n=0):
//   - All outputs are 0; DATA, new, overrun_cnt and freeze are 0; FSM goes to IDLE.
//   - A transfer in flight is abandoned with no ack.
// TESTING
//  1 Reset: Rst_n low mid-ACK -> Sl_xferAck drops immediately; reads then give DATA=0,
//    STATUS=0.
//  2 Capture+read: user_valid with 32'hDEADBEEF -> DATA reads DEADBEEF, STATUS=1 before
//    the read and 0 after; ack exactly one cycle after select.
//  3 Overrun: 3 captures with no read -> STATUS=32'h0002_0001; force count to FFFF, one
//    more capture -> count stays FFFF.
//  4 Collision: capture in the DATA-read ack cycle -> bus returns the old value; new=1;
//    count unchanged.
//  5 Control: write 1 with BE=4'b0001 -> freeze on, captures ignored; same write with
//    BE=4'b1110 -> no effect; write 2 -> count=0, new=0, CONTROL reads 0.
//  6 Decode: read at 0x10 -> acked, data 0; address C_HIGHADDR+4 -> no ack, Sl_DBus=0.

Source files
------------

// File: rtl/opb_register_simulink2ppc.sv
// Fabric-to-PowerPC status register on OPB: captures user samples, tracks a
// "new data" flag and a saturating overrun count, and exposes a small control
// register (freeze / clear). Bus bit 0 is the MSB of every register value.
module opb_register_simulink2ppc #(
  parameter logic [31:0] C_BASEADDR   = 32'h01060200,
  parameter logic [31:0] C_HIGHADDR   = 32'h010602FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter string       C_FAMILY     = "virtex5"
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  input  logic [31:0]             user_data_in,
  input  logic                    user_valid
);

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic        start;

  // register file
  logic [31:0] data_q;
  logic        new_q;
  logic [15:0] ovr_cnt_q;
  logic        freeze_q;

  // transfer latched on entry to ACK
  logic        rnw_q;
  logic [5:0]  idx_q;
  logic        be3_q;
  logic [7:0]  wbyte_q;
  logic [31:0] rdata_q;

  // Bus vectors re-viewed MSB-first so value[31] == bus bit 0.
  logic [31:0] abus_v, dbus_v, offset;
  logic [5:0]  widx;
  logic        in_range;
  logic [31:0] rd_mux;

  assign abus_v   = OPB_ABus;
  assign dbus_v   = OPB_DBus;
  assign in_range = (abus_v >= C_BASEADDR) && (abus_v <= C_HIGHADDR);
  assign offset   = abus_v - C_BASEADDR;
  assign widx     = offset[7:2];

  // Read mux over the word index; unmapped words read 0.
  always_comb begin
    rd_mux = '0;
    case (widx)
      6'd0:    rd_mux = data_q;
      6'd1:    rd_mux = {ovr_cnt_q, 15'd0, new_q};
      6'd2:    rd_mux = {31'd0, freeze_q};
      default: rd_mux = '0;
    endcase
  end

  // Bus FSM next state: one ack cycle then one dead cycle.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      S_IDLE: if (OPB_select && in_range) begin
        state_d = S_ACK;
        start   = 1'b1;
      end
      S_ACK:   state_d = S_HOLD;
      S_HOLD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register; reset abandons any transfer in flight.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // Latch the request and snapshot read data at the select edge.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      rnw_q   <= 1'b1;
      idx_q   <= '0;
      be3_q   <= 1'b0;
      wbyte_q <= '0;
      rdata_q <= '0;
    end else if (start) begin
      rnw_q   <= OPB_RNW;
      idx_q   <= widx;
      be3_q   <= OPB_BE[3];
      wbyte_q <= dbus_v[7:0];
      rdata_q <= OPB_RNW ? rd_mux : 32'd0;
    end
  end

  logic ack, rd_clr, ctrl_we, clr, cap;

  assign ack     = (state_q == S_ACK);
  assign rd_clr  = ack && rnw_q && (idx_q == 6'd0);
  assign ctrl_we = ack && !rnw_q && (idx_q == 6'd2) && be3_q;
  assign clr     = ctrl_we && wbyte_q[1];
  assign cap     = user_valid && !freeze_q;

  // Capture path and side effects. Priority on new/count: clear, then
  // capture, then the clearing DATA read.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      data_q    <= '0;
      new_q     <= 1'b0;
      ovr_cnt_q <= '0;
      freeze_q  <= 1'b0;
    end else begin
      if (cap) data_q <= user_data_in;
      if (clr) begin
        new_q     <= 1'b0;
        ovr_cnt_q <= '0;
      end else if (cap) begin
        new_q <= 1'b1;
        if (new_q && !rd_clr && (ovr_cnt_q != 16'hFFFF))
          ovr_cnt_q <= ovr_cnt_q + 16'd1;
      end else if (rd_clr) begin
        new_q <= 1'b0;
      end
      if (ctrl_we) freeze_q <= wbyte_q[0];
    end
  end

  // Outputs are zero outside the ack cycle so the OPB wired-OR stays clean.
  assign Sl_xferAck = ack;
  assign Sl_DBus    = ack ? rdata_q : '0;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  logic unused_ok;
  assign unused_ok = &{1'b0, OPB_seqAddr, dbus_v[31:8], offset[31:8], offset[1:0]};

endmodule

// File: tb/tb_opb_register_simulink2ppc.sv
// Self-checking bench: directed scenarios plus randomized traffic, checked
// against a transaction-level model of the register block.
module tb_opb_register_simulink2ppc;

  localparam logic [31:0] BASE = 32'h01060200;
  localparam logic [31:0] HIGH = 32'h010602FF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [0:31] abus, dbus, sl_dbus;
  logic [0:3]  be;
  logic        rnw, sel, seq;
  logic        ack, err, retry, tout;
  logic [31:0] ud;
  logic        uv;

  always #5 clk = ~clk;

  opb_register_simulink2ppc dut (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be),
    .OPB_DBus(dbus), .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq),
    .Sl_DBus(sl_dbus), .Sl_xferAck(ack), .Sl_errAck(err), .Sl_retry(retry),
    .Sl_toutSup(tout), .user_data_in(ud), .user_valid(uv)
  );

  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  logic [31:0] m_data;
  bit          m_new, m_freeze;
  int          m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_data = '0; m_new = 0; m_freeze = 0; m_cnt = 0;
  endtask

  function automatic logic [31:0] model_read(input int idx);
    case (idx)
      0:       return m_data;
      1:       return {16'(m_cnt), 15'd0, m_new};
      2:       return {31'd0, m_freeze};
      default: return 32'd0;
    endcase
  endfunction

  // One clock edge of the block's behaviour, from its register-level rules.
  task automatic model_step(input bit v, input logic [31:0] d, input bit rd_clr,
                            input bit cwe, input logic [7:0] cd);
    bit cap;
    cap = v && !m_freeze;
    if (cwe && cd[1]) begin
      m_new = 0; m_cnt = 0;
    end else if (cap) begin
      if (m_new && !rd_clr && m_cnt < 65535) m_cnt++;
      m_new = 1;
    end else if (rd_clr) m_new = 0;
    if (cap) m_data = d;
    if (cwe) m_freeze = cd[0];
  endtask

  task automatic tick(input bit rd_clr, input bit cwe, input logic [7:0] cd);
    @(posedge clk);
    model_step(uv, ud, rd_clr, cwe, cd);
    #1;
  endtask

  // Full OPB transfer; checks ack latency/width and read data.
  task automatic bus_xfer(input string tag, input bit r, input logic [31:0] addr,
                          input logic [0:3] b, input logic [31:0] wd,
                          input bit uvk, input logic [31:0] udk,
                          input bit uva, input logic [31:0] uda);
    logic [31:0] off, exp;
    bit inr;
    int idx;
    inr = (addr >= BASE) && (addr <= HIGH);
    off = addr - BASE;
    idx = int'(off[7:2]);
    exp = (inr && r) ? model_read(idx) : 32'd0;
    sel = 1; abus = addr; rnw = r; be = b; dbus = wd; uv = uvk; ud = udk;
    tick(0, 0, 8'd0);
    if (inr) begin
      sel = 0; uv = uva; ud = uda;
      chk({tag, "_ack"}, {31'd0, ack}, 32'd1);
      chk({tag, "_data"}, sl_dbus, exp);
      tick(r && idx == 0, !r && idx == 2 && b[3], wd[7:0]);
      uv = 0;
      chk({tag, "_ack1"}, {31'd0, ack}, 32'd0);
      chk({tag, "_dbus0"}, sl_dbus, 32'd0);
      tick(0, 0, 8'd0);
    end else begin
      uv = 0;
      repeat (3) begin
        chk({tag, "_noack"}, {31'd0, ack}, 32'd0);
        chk({tag, "_nodata"}, sl_dbus, 32'd0);
        tick(0, 0, 8'd0);
      end
      sel = 0;
    end
    rnw = 1; be = '0; dbus = '0;
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] e;
    e = model_read(int'((addr - BASE) >> 2));
    chk({tag, "_model"}, e, exp);
    bus_xfer(tag, 1, addr, 4'b0000, 32'd0, 0, 32'd0, 0, 32'd0);
  endtask

  task automatic capture(input logic [31:0] d);
    uv = 1; ud = d; tick(0, 0, 8'd0); uv = 0;
  endtask

  initial begin
    logic [31:0] addr, wd;
    int op;
    rst_n = 0; abus = '0; dbus = '0; be = '0; rnw = 1; sel = 0; seq = 0;
    uv = 0; ud = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_dbus", sl_dbus, 32'd0);
    chk("rst_tied", {29'd0, err, retry, tout}, 32'd0);
    rst_n = 1;
    tick(0, 0, 8'd0);

    // capture + read
    capture(32'hDEADBEEF);
    rd("st_new", BASE + 4, 32'h0000_0001);
    rd("data", BASE, 32'hDEADBEEF);
    rd("st_clr", BASE + 4, 32'h0000_0000);

    // overrun and saturation
    capture(32'h1); capture(32'h2); capture(32'h3);
    rd("ovr3", BASE + 4, 32'h0002_0001);
    uv = 1;
    for (int i = 0; i < 65540; i++) begin ud = i; tick(0, 0, 8'd0); end
    uv = 0;
    rd("ovr_sat", BASE + 4, 32'hFFFF_0001);

    // clear, then collision: capture during the DATA read ack cycle
    bus_xfer("clr", 0, BASE + 8, 4'b0001, 32'h2, 0, 0, 0, 0);
    rd("clr_st", BASE + 4, 32'h0000_0000);
    capture(32'hAAAA0001);
    bus_xfer("coll", 1, BASE, 4'b0000, 0, 0, 0, 1, 32'hBBBB0002);
    rd("coll_st", BASE + 4, 32'h0000_0001);
    rd("coll_data", BASE, 32'hBBBB0002);

    // control: freeze, byte gating, clear
    bus_xfer("frz", 0, BASE + 8, 4'b0001, 32'h1, 0, 0, 0, 0);
    capture(32'h12345678);
    rd("frz_data", BASE, 32'hBBBB0002);
    rd("frz_st", BASE + 4, 32'h0000_0000);
    bus_xfer("bemask", 0, BASE + 8, 4'b1110, 32'h0, 0, 0, 0, 0);
    rd("bemask_ctl", BASE + 8, 32'h0000_0001);
    bus_xfer("clr2", 0, BASE + 8, 4'b0001, 32'h2, 0, 0, 0, 0);
    rd("clr2_ctl", BASE + 8, 32'h0000_0000);
    capture(32'h55AA55AA);
    rd("unfrz_data", BASE, 32'h55AA55AA);

    // decode
    rd("dec_10", BASE + 32'h10, 32'h0);
    bus_xfer("dec_oor", 1, HIGH + 4, 4'b0000, 0, 0, 0, 0, 0);

    // reset in the middle of an ack cycle
    capture(32'hCAFEF00D);
    sel = 1; abus = BASE; rnw = 1;
    tick(0, 0, 8'd0);
    sel = 0;
    chk("mid_ack_pre", {31'd0, ack}, 32'd1);
    #2 rst_n = 0;
    #1;
    chk("mid_ack_drop", {31'd0, ack}, 32'd0);
    chk("mid_ack_dbus", sl_dbus, 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
    tick(0, 0, 8'd0);
    rd("rst_data", BASE, 32'h0);
    rd("rst_st", BASE + 4, 32'h0);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 9);
      case ($urandom_range(0, 6))
        0: addr = BASE;
        1: addr = BASE + 4;
        2: addr = BASE + 8;
        3: addr = BASE + 32'h10 + 4 * $urandom_range(0, 59);
        4: addr = HIGH - 3;
        5: addr = ($urandom_range(0, 1) != 0) ? HIGH + 4 : BASE - 4;
        default: addr = BASE;
      endcase
      if (op < 3) begin
        repeat ($urandom_range(1, 4)) begin
          uv = ($urandom_range(0, 2) != 0); ud = $urandom;
          tick(0, 0, 8'd0);
        end
        uv = 0;
      end else if (op < 8) begin
        bus_xfer("rnd_rd", 1, addr, 4'b0000, 0,
                 $urandom_range(0, 1) != 0, $urandom,
                 $urandom_range(0, 1) != 0, $urandom);
      end else begin
        wd = $urandom;
        if ($urandom_range(0, 3) != 0) wd[0] = 1'b0;
        if ($urandom_range(0, 2) != 0) wd[1] = 1'b0;
        bus_xfer("rnd_wr", 0, ($urandom_range(0, 1) != 0) ? BASE + 8 : addr,
                 4'($urandom), wd,
                 $urandom_range(0, 1) != 0, $urandom,
                 $urandom_range(0, 1) != 0, $urandom);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
